// File: rtl/commit_arbiter_pkg.sv
// commit_arbiter_pkg
//   Shared definitions for the commit path: datapath widths, commit packet
//   field ranges, reservation-station id width and the idle RSID encoding.
//   Imported by the commit arbiter, its interface and its sub-modules.
package commit_arbiter_pkg;

    localparam int DATA_ADDRESS_WIDTH = 16;
    localparam int DATA_ROW_WIDTH     = 96;
    localparam int RS_ID_WIDTH        = 4;
    localparam int RESULT_ID_WIDTH    = 4;
    localparam int WE_WIDTH           = 3;

    // RSID 0 on the commit bus means "no commit" to every station.
    localparam logic [RS_ID_WIDTH-1:0] RS_ID_IDLE = '0;

    localparam int MOD_COMMIT_DATA_LSB    = 0;
    localparam int MOD_COMMIT_DATA_MSB    = MOD_COMMIT_DATA_LSB + DATA_ROW_WIDTH - 1;
    localparam int MOD_COMMIT_TAG_LSB     = MOD_COMMIT_DATA_MSB + 1;
    localparam int MOD_COMMIT_TAG_MSB     = MOD_COMMIT_TAG_LSB + RESULT_ID_WIDTH - 1;
    localparam int MOD_COMMIT_RSID_LSB    = MOD_COMMIT_TAG_MSB + 1;
    localparam int MOD_COMMIT_RSID_MSB    = MOD_COMMIT_RSID_LSB + RS_ID_WIDTH - 1;
    localparam int MOD_COMMIT_PACKET_SIZE = MOD_COMMIT_RSID_MSB + 1;

    // Register-file write port as captured at the grant edge.
    typedef struct packed {
        logic                          writeEnable;
        logic [WE_WIDTH-1:0]           we;
        logic [DATA_ADDRESS_WIDTH-1:0] address;
        logic [DATA_ROW_WIDTH-1:0]     data;
    } rfWrite_t;

    function automatic logic [MOD_COMMIT_PACKET_SIZE-1:0] packCommit(
        input logic [RS_ID_WIDTH-1:0]     rsId,
        input logic [RESULT_ID_WIDTH-1:0] tag,
        input logic [DATA_ROW_WIDTH-1:0]  data
    );
        logic [MOD_COMMIT_PACKET_SIZE-1:0] packet;
        packet = '0;
        packet[MOD_COMMIT_RSID_MSB:MOD_COMMIT_RSID_LSB] = rsId;
        packet[MOD_COMMIT_TAG_MSB:MOD_COMMIT_TAG_LSB]   = tag;
        packet[MOD_COMMIT_DATA_MSB:MOD_COMMIT_DATA_LSB] = data;
        return packet;
    endfunction

endpackage

// File: rtl/commit_arbiter_if.sv
// commit_arbiter_if
//   Bundles the reservation-station commit requests/results and the
//   arbiter's broadcast / register-file outputs.
//   i* : per-station requests and packed result fields, plus iFreeze
//   o* : grant vector, commit bus packet, RF write port, commit counter
//   slave  : the arbiter side
//   master : the station / environment side
interface commit_arbiter_if
    import commit_arbiter_pkg::*;
#(
    parameter int RS_COUNT = 8
);

    logic [RS_COUNT-1:0]                    iCommitRequest;
    logic [RESULT_ID_WIDTH*RS_COUNT-1:0]    iId;
    logic [WE_WIDTH*RS_COUNT-1:0]           iWE;
    logic [DATA_ADDRESS_WIDTH*RS_COUNT-1:0] iDestination;
    logic [DATA_ROW_WIDTH*RS_COUNT-1:0]     iResult;
    logic                                   iFreeze;

    logic [RS_COUNT-1:0]                    oCommitGranted;
    logic [MOD_COMMIT_PACKET_SIZE-1:0]      oCommitBus;
    logic                                   oRFWriteEnable;
    logic [WE_WIDTH-1:0]                    oRFWE;
    logic [DATA_ADDRESS_WIDTH-1:0]          oRFAddress;
    logic [DATA_ROW_WIDTH-1:0]              oRFData;
    logic [15:0]                            oCommitCount;

    modport master (
        output iCommitRequest, iId, iWE, iDestination, iResult, iFreeze,
        input  oCommitGranted, oCommitBus, oRFWriteEnable, oRFWE,
               oRFAddress, oRFData, oCommitCount
    );

    modport slave (
        input  iCommitRequest, iId, iWE, iDestination, iResult, iFreeze,
        output oCommitGranted, oCommitBus, oRFWriteEnable, oRFWE,
               oRFAddress, oRFData, oCommitCount
    );

endinterface

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// FFD_POSEDGE_SYNCRONOUS_RESET
//   Codebase register cell: rising-edge flop bank with synchronous
//   active-high reset to zero and a load enable.
//   Clock, Reset, Enable : control
//   D / Q                : SIZE-bit data in / registered data out
module FFD_POSEDGE_SYNCRONOUS_RESET #(
    parameter int SIZE = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/rr_priority_select.sv
// rr_priority_select
//   Combinational round-robin selector. Searches iRequest starting at
//   iPointer, wrapping modulo REQ_COUNT, and returns the first set bit.
//   iRequest     : request vector
//   iPointer     : highest-priority index (0..REQ_COUNT-1)
//   oWinner      : one-hot winner, zero when nothing is requested
//   oWinnerIndex : binary index of the winner
//   oAnyValid    : at least one request present
module rr_priority_select
    import commit_arbiter_pkg::*;
#(
    parameter int REQ_COUNT = 8
) (
    input  logic [REQ_COUNT-1:0]   iRequest,
    input  logic [RS_ID_WIDTH-1:0] iPointer,
    output logic [REQ_COUNT-1:0]   oWinner,
    output logic [RS_ID_WIDTH-1:0] oWinnerIndex,
    output logic                   oAnyValid
);

    // Wrap-around search as two ascending passes: indices at or above the
    // pointer first, then everything from zero.
    always_comb begin
        oWinner      = '0;
        oWinnerIndex = '0;
        oAnyValid    = 1'b0;
        for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            if (!oAnyValid && iRequest[k] && (k >= 32'(iPointer))) begin
                oAnyValid    = 1'b1;
                oWinner[k]   = 1'b1;
                oWinnerIndex = RS_ID_WIDTH'(k);
            end
        end
        for (int unsigned k = 0; k < REQ_COUNT; k++) begin
            if (!oAnyValid && iRequest[k]) begin
                oAnyValid    = 1'b1;
                oWinner[k]   = 1'b1;
                oWinnerIndex = RS_ID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter
//   Round-robin arbiter granting one reservation station per cycle access
//   to the commit bus and the register-file write port.
//   Clock, Reset           : rising-edge clock, synchronous active-high reset
//   bus.iCommitRequest     : one request bit per station (bit k = RS id k+1)
//   bus.iId/iWE/iDestination/iResult : packed per-station result fields
//   bus.iFreeze            : suppresses granting
//   bus.oCommitGranted     : combinational one-hot-or-zero grant
//   bus.oCommitBus         : registered packet {RSID, tag, data}, RSID 0 = idle
//   bus.oRF*               : registered register-file write port
//   bus.oCommitCount       : grants since reset, wraps at 16 bits
module commit_arbiter
    import commit_arbiter_pkg::*;
#(
    parameter int RS_COUNT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    commit_arbiter_if.slave   bus
);

    localparam logic [RS_ID_WIDTH-1:0] LAST_INDEX = RS_ID_WIDTH'(RS_COUNT - 1);

    logic [RS_ID_WIDTH-1:0]            pointer;
    logic [RS_COUNT-1:0]               winnerOneHot;
    logic [RS_ID_WIDTH-1:0]            winnerIndex;
    logic                              anyValid;
    logic                              grantValid;

    logic [RESULT_ID_WIDTH-1:0]        selId;
    logic [WE_WIDTH-1:0]               selWE;
    logic [DATA_ADDRESS_WIDTH-1:0]     selDestination;
    logic [DATA_ROW_WIDTH-1:0]         selResult;

    logic [MOD_COMMIT_PACKET_SIZE-1:0] packetNext;
    rfWrite_t                          rfNext;
    rfWrite_t                          rfQ;
    logic [15:0]                       commitCount;

    rr_priority_select #(
        .REQ_COUNT (RS_COUNT)
    ) prioritySelect (
        .iRequest     (bus.iCommitRequest),
        .iPointer     (pointer),
        .oWinner      (winnerOneHot),
        .oWinnerIndex (winnerIndex),
        .oAnyValid    (anyValid)
    );

    // Reset also masks the grant so an in-flight capture is discarded.
    assign grantValid         = anyValid & ~bus.iFreeze & ~Reset;
    assign bus.oCommitGranted = grantValid ? winnerOneHot : '0;

    // AND-OR mux of the winner's fields, driven by the one-hot vector.
    always_comb begin
        selId          = '0;
        selWE          = '0;
        selDestination = '0;
        selResult      = '0;
        for (int unsigned k = 0; k < RS_COUNT; k++) begin
            if (winnerOneHot[k]) begin
                selId          = bus.iId[k*RESULT_ID_WIDTH +: RESULT_ID_WIDTH];
                selWE          = bus.iWE[k*WE_WIDTH +: WE_WIDTH];
                selDestination = bus.iDestination[k*DATA_ADDRESS_WIDTH +: DATA_ADDRESS_WIDTH];
                selResult      = bus.iResult[k*DATA_ROW_WIDTH +: DATA_ROW_WIDTH];
            end
        end
    end

    // Idle cycles load zeros, so RSID returns to RS_ID_IDLE one cycle later.
    always_comb begin
        packetNext = packCommit(RS_ID_IDLE, '0, '0);
        rfNext     = '0;
        if (grantValid) begin
            packetNext         = packCommit(winnerIndex + RS_ID_WIDTH'(1), selId, selResult);
            rfNext.writeEnable = |selWE;
            rfNext.we          = selWE;
            rfNext.address     = selDestination;
            rfNext.data        = selResult;
        end
    end

    FFD_POSEDGE_SYNCRONOUS_RESET #(
        .SIZE (MOD_COMMIT_PACKET_SIZE)
    ) commitBusReg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (1'b1),
        .D      (packetNext),
        .Q      (bus.oCommitBus)
    );

    FFD_POSEDGE_SYNCRONOUS_RESET #(
        .SIZE ($bits(rfWrite_t))
    ) rfWriteReg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (1'b1),
        .D      (rfNext),
        .Q      (rfQ)
    );

    assign bus.oRFWriteEnable = rfQ.writeEnable;
    assign bus.oRFWE          = rfQ.we;
    assign bus.oRFAddress     = rfQ.address;
    assign bus.oRFData        = rfQ.data;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pointer     <= '0;
            commitCount <= '0;
        end else if (grantValid) begin
            pointer     <= (winnerIndex == LAST_INDEX) ? '0 : winnerIndex + RS_ID_WIDTH'(1);
            commitCount <= commitCount + 16'd1;
        end
    end

    assign bus.oCommitCount = commitCount;

endmodule

// File: doc/commit_arbiter.md
COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 SHALL have parameter RS_COUNT, default 8, meaning the number of reservation stations served, with legal range 1..15.
REQ-002 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port iCommitRequest, input, RS_COUNT, one bit per station; bit k is the request of RS id k+1.
REQ-005 SHALL have port iId, input, 4*RS_COUNT, the packed per-station result id/tag.
REQ-006 SHALL have port iWE, input, 3*RS_COUNT, the packed per-station write-enable masks (x,y,z).
REQ-007 SHALL have port iDestination, input, `DATA_ADDRESS_WIDTH*RS_COUNT, the packed per-station destination.
REQ-008 SHALL have port iResult, input, `DATA_ROW_WIDTH*RS_COUNT, the packed per-station result data.
REQ-009 SHALL have port iFreeze, input, 1; when high, no grant is issued.
REQ-010 SHALL have port oCommitGranted, output, RS_COUNT, one-hot-or-zero grant, combinational.
REQ-011 SHALL have port oCommitBus, output, `MOD_COMMIT_PACKET_SIZE, the registered broadcast packet (RSID, tag, data fields at the `MOD_COMMIT_*_RNG positions).
REQ-012 SHALL have ports oRFWriteEnable (1), oRFWE (3), oRFAddress (`DATA_ADDRESS_WIDTH), oRFData (`DATA_ROW_WIDTH), all outputs, the registered register-file write port.
REQ-013 SHALL have port oCommitCount, output, 16, the total grants since reset.

Function
REQ-014 SHALL grant at most one station per cycle: oCommitGranted = round-robin winner among iCommitRequest when iFreeze=0; all-zero otherwise.
REQ-015 SHALL hold a priority pointer P (0..RS_COUNT-1); search order P, P+1, ... wrapping modulo RS_COUNT.
REQ-016 SHALL set P to (winner+1) mod RS_COUNT on the edge ending a grant cycle; P unchanged on cycles with no grant.
REQ-017 SHALL capture the winner's fields at the same edge: oCommitBus RSID = winner+1, tag = iId[winner], data = iResult[winner]; latency grant to bus = 1 cycle.
REQ-018 SHALL drive oCommitBus RSID field = 0 and all other fields 0 in every cycle following a cycle with no grant; RSID 0 means "no commit" to all stations.
REQ-019 SHALL assert oRFWriteEnable for exactly the cycle oCommitBus carries a nonzero RSID, with oRFWE/oRFAddress/oRFData = winner's iWE/iDestination/iResult; oRFWE=0 forces oRFWriteEnable=0.
REQ-020 SHALL increment oCommitCount by 1 per grant, wrapping 0xFFFF -> 0x0000.
REQ-021 SHALL treat a request asserted in the cycle its previous grant is issued as a new request only if still high the next cycle (no double grant of one result).
REQ-022 iFreeze rising mid-stream: current-cycle grant suppressed, packet already on oCommitBus still completes its single cycle.
REQ-023 Request bits above RS_COUNT do not exist; id 0 is never granted.

Reset
REQ-024 On Reset=1 at an edge: P=0, oCommitBus=0, oRFWriteEnable=0, oRFWE=0, oRFAddress=0, oRFData=0, oCommitCount=0.
REQ-025 While Reset=1, oCommitGranted SHALL be all-zero regardless of requests; reset mid-grant discards the in-flight capture.

Structure
REQ-026 Commit packet field ranges, RS id width and RSID-0 "idle" encoding SHALL live in the shared definitions include (aDefinitions.v), not in the module.
REQ-027 SHALL instantiate one sub-module, rr_priority_select (requests, pointer -> one-hot winner, index, any-valid), combinational.
REQ-028 Output registers SHALL use the codebase's FFD_POSEDGE_SYNCRONOUS_RESET cell; pointer and counter may be behavioural.

Verification
REQ-029 Single request: RS3 requests with data 0xA5.., after reset -> grant bit2 in cycle t, oCommitBus RSID=3, data 0xA5.., oRFWriteEnable=1 in t+1, P=3.
REQ-030 All 8 request continuously -> grants RS1,RS2,...,RS8,RS1 on consecutive cycles; oCommitCount=9 after 9 cycles.
REQ-031 Pointer wrap: P=7, requests RS2 and RS8 -> RS8 first, then RS2; P then 2.
REQ-032 iFreeze=1 for 3 cycles with RS5 requesting -> no grant, RSID=0 on bus; grant RS5 on first cycle iFreeze=0.
REQ-033 Reset asserted during grant of RS4 -> next cycle oCommitBus=0, oRFWriteEnable=0, oCommitCount=0, P=0.
REQ-034 RS6 requests with WE=0 -> granted, RSID=6 broadcast, oRFWriteEnable=0.
